// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads program memory at the current PC, buffers one
// fetched word and offers it to decode. Advances the PC on every accepted word
// and loads it on a redirect, discarding whatever fetch was in flight.
//
// Handshake: a word moves to decode on a cycle where instr_valid and instr_ready
// are both 1. instr_valid does not wait for instr_ready. instr_valid,
// instr_data and instr_pc hold steady until the word moves or a redirect
// arrives. A redirect in the same cycle cancels the move.
module instr_fetch #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;

  // A redirect suppresses the read strobe: that read would be dropped anyway.
  assign mem_en      = (state == S_REQ) && !redirect_valid;
  assign mem_addr    = pc_in;
  // The PC advances only for a completed handshake that a redirect did not cancel.
  assign pc_inc      = (state == S_HOLD) && instr_ready && !redirect_valid;
  // Gated with rstn so that no load is requested while reset is held.
  assign pc_load     = redirect_valid && rstn;
  assign pc_load_val = redirect_pc;
  assign dbg_state   = state;

  // Fetch sequencer with the output buffer; a redirect overrides every state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      if (state == S_IDLE) state <= en ? S_REQ : S_IDLE;
      else                 state <= S_REQ;
    end else begin
      case (state)
        S_IDLE: if (en) state <= S_REQ;
        S_REQ: begin
          addr_q <= pc_in;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          instr_data  <= mem_rdata;
          instr_pc    <= addr_q;
          instr_valid <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= en ? S_REQ : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program counter and a synchronous ROM surround the
// DUT. A scoreboard of expected {pc, word} entries is checked by a monitor on
// each handshake. Directed scenarios are followed by a randomized run.
module tb_instr_fetch;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int EW = AW + DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] pc_in;
  logic          pc_inc, pc_load;
  logic [AW-1:0] pc_load_val;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [1:0]    dbg_state;

  logic [DW-1:0] rom [2**AW];
  logic [EW-1:0] exp_q[$];
  int            inc_t[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .pc_in(pc_in), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Program counter model
  always @(posedge clk or negedge rstn) begin
    if (!rstn)        pc_in <= '0;
    else if (pc_load) pc_in <= pc_load_val;
    else if (pc_inc)  pc_in <= pc_in + 1'b1;
  end

  // Program ROM: data valid one cycle after mem_en, junk otherwise
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom[mem_addr];
    else        mem_rdata <= DW'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [AW-1:0] p);
    return {p, rom[p]};
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  logic          prev_valid, prev_ready, prev_redir, prev_mem_en;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_pc;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [AW-1:0] np;
    cyc++;
    if (!rstn) begin
      prev_valid = 0; prev_ready = 0; prev_redir = 0; prev_mem_en = 0;
      prev_data = '0; prev_pc = '0;
    end else begin
      chk("pc_inc_rule", 32'(pc_inc), 32'(instr_valid & instr_ready & ~redirect_valid));
      chk("pc_load_rule", 32'(pc_load), 32'(redirect_valid));
      if (redirect_valid) chk("pc_load_val", 32'(pc_load_val), 32'(redirect_pc));
      if (mem_en) begin
        chk("mem_addr_eq_pc", 32'(mem_addr), 32'(pc_in));
        chk("mem_en_while_valid", 32'(instr_valid), 0);
      end
      if (prev_mem_en && !prev_redir) chk("mem_en_back_to_back", 32'(mem_en), 0);
      if (prev_redir) chk("valid_after_redirect", 32'(instr_valid), 0);
      else if (prev_valid && !prev_ready) begin
        chk("stall_valid", 32'(instr_valid), 1);
        chk("stall_data", 32'(instr_data), 32'(prev_data));
        chk("stall_pc", 32'(instr_pc), 32'(prev_pc));
      end
      if (!redirect_valid && instr_valid && instr_ready) begin
        inc_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_unexpected: actual pc=%0d data=%0h required=none", instr_pc, instr_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_pc", 32'(instr_pc), 32'(e[EW-1:DW]));
          chk("word_data", 32'(instr_data), 32'(e[DW-1:0]));
          np = e[EW-1:DW] + 1'b1;
          exp_q.push_back(ent(np));
        end
      end
      prev_valid = instr_valid; prev_ready = instr_ready; prev_redir = redirect_valid;
      prev_mem_en = mem_en; prev_data = instr_data; prev_pc = instr_pc;
    end
  end

  // Driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!instr_valid && k < 30) begin step(); k++; end
    if (!instr_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_mem_en(input string name);
    int k = 0;
    while (!mem_en && k < 30) begin step(); k++; end
    if (!mem_en) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_redirect(input logic [AW-1:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
    exp_q.push_back(ent(t));
    #1;
    chk("redirect_pc_load", 32'(pc_load), 1);
    chk("redirect_no_inc", 32'(pc_inc), 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("pc_load_one_cycle", 32'(pc_load), 0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    exp_q.delete();
    exp_q.push_back(ent('0));
  endtask

  // Stimulus
  initial begin
    int n0, k;
    logic [DW-1:0] d0;
    logic [AW-1:0] p0;
    for (int i = 0; i < 2**AW; i++) rom[i] = DW'(8'hA0 + i);
    apply_reset();
    #3;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_data", 32'(instr_data), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_pc_inc", 32'(pc_inc), 0);
    chk("rst_pc_load", 32'(pc_load), 0);
    chk("rst_state", 32'(dbg_state), 0);
    step(2);
    rstn = 1'b1;

    // T2: stream from PC 0 through the wrap; one accepted word every 3 cycles
    en = 1'b1; instr_ready = 1'b1;
    n0 = inc_t.size(); k = 0;
    while (inc_t.size() < n0 + 9 && k < 60) begin step(); k++; end
    chk("t2_word_count", 32'(inc_t.size() >= n0 + 9), 1);
    if (inc_t.size() >= n0 + 9)
      for (int i = 1; i < 9; i++) chk("t2_gap", 32'(inc_t[n0+i] - inc_t[n0+i-1]), 3);

    // T3: backpressure holds the word, release gives exactly one increment
    instr_ready = 1'b0;
    wait_valid("t3_valid");
    d0 = instr_data; p0 = instr_pc;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(instr_valid), 1);
      chk("t3_hold_data", 32'(instr_data), 32'(d0));
      chk("t3_hold_pc", 32'(instr_pc), 32'(p0));
      chk("t3_no_inc", 32'(pc_inc), 0);
      step();
    end
    instr_ready = 1'b1;
    n0 = inc_t.size();
    step(3);
    chk("t3_single_inc", 32'(inc_t.size() - n0), 1);

    // T4: redirect while holding the word at PC 2
    instr_ready = 1'b0;
    do_redirect(3'd2);
    wait_valid("t4_valid2");
    chk("t4_at_pc2", 32'(instr_pc), 2);
    do_redirect(3'd6);
    wait_valid("t4_valid6");
    chk("t4_pc6", 32'(instr_pc), 6);
    chk("t4_data6", 32'(instr_data), 32'(8'hA6));
    instr_ready = 1'b1;
    step();

    // T5: redirect in WAIT, then coincident with a handshake
    wait_mem_en("t5_req");
    step();
    do_redirect(3'd5);
    instr_ready = 1'b0;
    wait_valid("t5_valid5");
    chk("t5_pc5", 32'(instr_pc), 5);
    instr_ready = 1'b1;
    do_redirect(3'd1);
    wait_valid("t5_valid1");
    chk("t5_pc1", 32'(instr_pc), 1);
    step();

    // T6: en drop in WAIT completes the word, parks, then resumes at PC+1
    wait_mem_en("t6_req");
    step();
    en = 1'b0;
    wait_valid("t6_valid");
    p0 = instr_pc;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_idle_mem_en", 32'(mem_en), 0);
      chk("t6_idle_valid", 32'(instr_valid), 0);
      step();
    end
    en = 1'b1;
    wait_valid("t6_resume");
    chk("t6_resume_pc", 32'(instr_pc), 32'(AW'(p0 + 1'b1)));

    // T1: asynchronous reset in the middle of HOLD
    instr_ready = 1'b0;
    step();
    wait_valid("t1_valid");
    #3;
    apply_reset();
    #1;
    chk("t1_valid", 32'(instr_valid), 0);
    chk("t1_mem_en", 32'(mem_en), 0);
    chk("t1_pc_inc", 32'(pc_inc), 0);
    chk("t1_pc_load", 32'(pc_load), 0);
    step(2);
    rstn = 1'b1;

    // Randomized run
    n0 = inc_t.size();
    for (int i = 0; i < 600; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      instr_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = AW'($urandom);
        exp_q.delete();
        exp_q.push_back(ent(redirect_pc));
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 32'(inc_t.size() > n0 + 20), 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
